// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: drives one operand bit pair per cycle into an external
// registered full adder and assembles the result. Optional overflow flag: SERIAL_ADD_OVF_EN.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             cmsb_q, cmsb_d;
  logic             ovf_q, ovf_d;
`endif

  // The adder returns bit k's sum/carry one cycle after bit k is driven, so the
  // capture index lags the drive index by one and the last bit lands in DRAIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    cmsb_d    = cmsb_q;
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        fa_a  = a_q[cnt_q];
        fa_b  = b_q[cnt_q];
        fa_ci = (cnt_q == '0) ? cin_q : fa_co;
        if (cnt_q != '0) begin
          sum_d[cnt_q - 1'b1] = fa_s;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
`ifdef SERIAL_ADD_OVF_EN
          // Carry returned here is the carry out of bit WIDTH-2, i.e. into the MSB.
          cmsb_d  = fa_co;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DRAIN: begin
        sum_d[WIDTH-1] = fa_s;
        cout_d         = fa_co;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d          = cmsb_q ^ fa_co;
`endif
        state_d        = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand holding registers are only read in RUN after an accept has loaded them.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign out_ovf  = ovf_q;
`endif

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(in_ready && out_valid));

  a_fa_quiet: assert property (@(posedge clk) disable iff (!rstn)
    (state_q != RUN) |-> !(fa_a || fa_b || fa_ci));

  a_cnt_range: assert property (@(posedge clk) disable iff (!rstn)
    cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized self-checking bench for serial_add_seq, including a behavioural
// registered full adder on the fa_* side and an arithmetic reference model.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         fa_a, fa_b, fa_ci;
  logic         fa_s, fa_co;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         out_ovf;
`endif

  int passes = 0;
  int total  = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_ci     (fa_ci),
    .fa_s      (fa_s),
    .fa_co     (fa_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Downstream registered full adder.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fa_s  <= 1'b0;
      fa_co <= 1'b0;
    end else begin
      fa_s  <= fa_a ^ fa_b ^ fa_ci;
      fa_co <= (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passes++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Carry into bit k of a + b + cin, from plain arithmetic on the low k bits.
  function automatic logic [W-1:0] model_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic cin);
    logic [W-1:0] c;
    longint unsigned mask;
    longint unsigned part;
    for (int k = 0; k < W; k++) begin
      mask = (64'd1 << k) - 64'd1;
      part = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
      c[k] = part[k];
    end
    return c;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int hold);
    logic [W:0]   full;
    logic [W-1:0] obs_a, obs_b, obs_c, exp_c, held_sum;
    logic [2:0]   drain_fa;
    logic         busy_ready, stable;
    int           edges;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_c = model_carries(a, b, cin);
    obs_a = '0; obs_b = '0; obs_c = '0; drain_fa = 3'b111;
    busy_ready = 1'b0;
    wait_idle();
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    // Keep offering different operands; they must be ignored while busy.
    in_a   = W'($urandom);
    in_b   = W'($urandom);
    in_cin = 1'($urandom);
    edges  = 0;
    while (!out_valid && edges <= W + 4) begin
      if (edges < W) begin
        obs_a[edges] = fa_a;
        obs_b[edges] = fa_b;
        obs_c[edges] = fa_ci;
      end else if (edges == W) begin
        drain_fa = {fa_a, fa_b, fa_ci};
      end
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    chk("latency", edges, W + 1);
    chk("fa_a_bits", {24'd0, obs_a}, {24'd0, a});
    chk("fa_b_bits", {24'd0, obs_b}, {24'd0, b});
    chk("fa_ci_bits", {24'd0, obs_c}, {24'd0, exp_c});
    chk("drain_fa_zero", {29'd0, drain_fa}, 32'd0);
    chk("busy_in_ready", {31'd0, busy_ready}, 32'd0);
    chk("sum", {24'd0, out_sum}, {24'd0, full[W-1:0]});
    chk("cout", {31'd0, out_cout}, {31'd0, full[W]});
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", {31'd0, out_ovf},
        {31'd0, (a[W-1] == b[W-1]) && (full[W-1] != a[W-1])});
`endif
    if (hold > 0) begin
      held_sum = out_sum;
      stable   = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        if (out_sum !== held_sum || out_cout !== full[W] || !out_valid || in_ready)
          stable = 1'b0;
      end
      chk("hold_stable", {31'd0, stable}, 32'd1);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("back_to_idle", {30'd0, in_ready, out_valid}, 32'b10);
    out_ready = 1'b0;
  endtask

  initial begin
    logic any_valid;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("rst_fa", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_txn(8'h5A, 8'h33, 1'b0, 0);
    run_txn(8'hFF, 8'h01, 1'b0, 0);
    run_txn(8'hFF, 8'hFF, 1'b1, 0);
    run_txn(8'h12, 8'h34, 1'b1, 5);
    run_txn(8'h7F, 8'h01, 1'b0, 0);
    run_txn(8'h80, 8'h80, 1'b0, 2);
    run_txn(8'h00, 8'h00, 1'b0, 0);

    // Reset in the middle of a computation.
    wait_idle();
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'h00;
    in_cin   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_sum", {24'd0, out_sum}, 32'd0);
    chk("midrst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("midrst_fa", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    chk("midrst_no_valid", {31'd0, any_valid}, 32'd0);
    run_txn(8'h01, 8'h01, 1'b0, 0);

    for (int t = 0; t < 20; t++) begin
      run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
